// File: rtl/flofifo_pkg.sv
// Shared definitions for the flofifo drain path: FSM encoding, skid depth and
// the burst header layout on the 32-bit host stream.
package flofifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam int SKID_DEPTH  = 3;
  localparam int OUT_WIDTH   = 32;
  localparam int HDR_TAG_LSB = 24;
  localparam int HDR_SEQ_LSB = 16;
  localparam int HDR_LEN_LSB = 0;

  function automatic logic [OUT_WIDTH-1:0] make_header(input logic [7:0]  tag,
                                                       input logic [7:0]  seq,
                                                       input logic [15:0] len);
    logic [OUT_WIDTH-1:0] h;
    h = '0;
    h[HDR_TAG_LSB +: 8]  = tag;
    h[HDR_SEQ_LSB +: 8]  = seq;
    h[HDR_LEN_LSB +: 16] = len;
    return h;
  endfunction

endpackage

// File: rtl/flo_skid3.sv
// Three-entry synchronous buffer between the FIFO read port and the stream
// output; occupancy is exported so the pop logic can reserve space.
module flo_skid3
  import flofifo_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic [1:0]       wp;
  logic [1:0]       rp;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= 2'd0;
      rp  <= 2'd0;
      occ <= 2'd0;
    end else begin
      if (wr_en) wp <= ptr_inc(wp);
      if (rd_en) rp <= ptr_inc(rp);
      if (wr_en && !rd_en)      occ <= occ + 2'd1;
      else if (!wr_en && rd_en) occ <= occ - 2'd1;
    end
  end

  assign rd_data = mem[rp];
  assign empty   = (occ == 2'd0);

endmodule

// File: rtl/flofifo_drain.sv
// Drains the RX sample FIFO into framed bursts (header + N data words) on a
// 32-bit valid/ready stream; bursts start on a full BURST or after a timeout.
module flofifo_drain
  import flofifo_pkg::*;
#(
  parameter int         LENGTH  = 32,
  parameter int         WIDTH   = 24,
  parameter int         BURST   = 8,
  parameter int         TIMEOUT = 1000,
  parameter logic [7:0] TAG     = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable_i,
  input  logic [WIDTH-1:0]          fifo_data_i,
  input  logic                      fifo_valid_i,
  input  logic [$clog2(LENGTH)-1:0] fifo_locs_i,
  input  logic                      fifo_empty_i,
  input  logic                      fifo_full_i,
  output logic                      fifo_read_o,
  output logic [OUT_WIDTH-1:0]      data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      last_o,
  output logic                      busy_o,
  output logic [7:0]                seq_o
);

  localparam int            TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_MAX = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       seq;
  logic [TW-1:0]    tcnt;
  logic [15:0]      burst_len;
  logic [15:0]      pops_left;
  logic [15:0]      words_left;
  logic [15:0]      latch_len;
  logic             latch;
  logic [31:0]      avail;
  logic             in_burst;
  logic             room;
  logic             pop_p0;
  logic             vld_p1;
  logic             skid_wr;
  logic             skid_empty;
  logic [1:0]       skid_occ;
  logic [WIDTH-1:0] skid_q;
  logic             xfer;
  logic             data_xfer;

  function automatic logic [TW-1:0] tcnt_sat_inc(input logic [TW-1:0] t);
    return (t == T_MAX) ? t : t + TW'(1);
  endfunction

  // locs wraps to zero when the FIFO is full, so full overrides it
  assign avail    = fifo_full_i ? 32'(LENGTH) : 32'(fifo_locs_i);
  assign in_burst = (state != ST_IDLE);

  // Stage p0: pop issue; space is reserved for words still in flight so the
  // decision depends only on registered state, never on ready_i.
  assign room   = ({1'b0, skid_occ} + {2'b00, vld_p1}) < 3'(SKID_DEPTH);
  assign pop_p0 = !rst && in_burst && (pops_left != 16'd0) && !fifo_empty_i && room;

  // Stage p1: FIFO word lands in the skid buffer one cycle after the pop.
  assign skid_wr = vld_p1 && fifo_valid_i;

  flo_skid3 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (skid_wr),
    .wr_data (fifo_data_i),
    .rd_en   (data_xfer),
    .rd_data (skid_q),
    .empty   (skid_empty),
    .occ     (skid_occ)
  );

  assign xfer        = valid_o && ready_i;
  assign data_xfer   = (state == ST_DRAIN) && xfer;
  assign fifo_read_o = pop_p0;
  assign busy_o      = in_burst;
  assign seq_o       = seq;

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    latch_len = 16'(BURST);
    valid_o   = 1'b0;
    last_o    = 1'b0;
    data_o    = '0;
    case (state)
      ST_IDLE: begin
        if (enable_i && avail >= 32'(BURST)) begin
          state_nxt = ST_HEADER;
          latch     = 1'b1;
        end else if (enable_i && TIMEOUT != 0 && tcnt == T_MAX && !fifo_empty_i) begin
          state_nxt = ST_HEADER;
          latch     = 1'b1;
          latch_len = avail[15:0];
        end
      end
      ST_HEADER: begin
        valid_o = 1'b1;
        data_o  = make_header(TAG, seq, burst_len);
        if (ready_i) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        valid_o = !skid_empty;
        data_o  = skid_empty ? '0 : OUT_WIDTH'(skid_q);
        last_o  = !skid_empty && (words_left == 16'd1);
        if (valid_o && ready_i && words_left == 16'd1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      seq        <= 8'd0;
      tcnt       <= '0;
      burst_len  <= 16'd0;
      pops_left  <= 16'd0;
      words_left <= 16'd0;
      vld_p1     <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= pop_p0;
      if (latch) begin
        burst_len  <= latch_len;
        pops_left  <= latch_len;
        words_left <= latch_len;
      end else begin
        if (pop_p0)    pops_left  <= pops_left - 16'd1;
        if (data_xfer) words_left <= words_left - 16'd1;
      end
      if (data_xfer && words_left == 16'd1) seq <= seq + 8'd1;
      // saturating so a partial fill flushes as soon as enable_i returns
      if (in_burst || state_nxt != ST_IDLE || avail == 32'd0 || avail >= 32'(BURST))
        tcnt <= '0;
      else
        tcnt <= tcnt_sat_inc(tcnt);
    end
  end

endmodule

// File: tb/tb_flofifo_drain.sv
// Bench for flofifo_drain: behavioural FIFO, stream monitor and a burst-level
// reference model built from the written samples.
module tb_flofifo_drain;

  localparam int LENGTH  = 32;
  localparam int WIDTH   = 24;
  localparam int BURST   = 8;
  localparam int TIMEOUT = 50;
  localparam int LW      = $clog2(LENGTH);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable_i = 1'b0;
  logic             ready_i = 1'b1;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             fifo_valid = 1'b0;
  logic [LW-1:0]    fifo_locs;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_read;
  logic [31:0]      data_o;
  logic             valid_o;
  logic             last_o;
  logic             busy_o;
  logic [7:0]       seq_o;

  always #5 clk = ~clk;

  flofifo_drain #(
    .LENGTH (LENGTH), .WIDTH (WIDTH), .BURST (BURST), .TIMEOUT (TIMEOUT), .TAG (8'hA5)
  ) dut (
    .clk (clk), .rst (rst), .enable_i (enable_i),
    .fifo_data_i (fifo_data), .fifo_valid_i (fifo_valid), .fifo_locs_i (fifo_locs),
    .fifo_empty_i (fifo_empty), .fifo_full_i (fifo_full), .fifo_read_o (fifo_read),
    .data_o (data_o), .valid_o (valid_o), .ready_i (ready_i), .last_o (last_o),
    .busy_o (busy_o), .seq_o (seq_o)
  );

  // Upstream FIFO model with one-cycle read latency
  logic [WIDTH-1:0] mem [LENGTH];
  logic [LW-1:0]    wp = '0, rp = '0;
  logic [LW:0]      cnt = '0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;

  assign fifo_locs  = cnt[LW-1:0];
  assign fifo_full  = (cnt == (LW+1)'(LENGTH));
  assign fifo_empty = (cnt == '0);

  always @(posedge clk) begin
    if (rst) begin
      wp <= '0; rp <= '0; cnt <= '0; fifo_valid <= 1'b0;
    end else begin
      fifo_valid <= fifo_read;
      if (fifo_read) begin
        fifo_data <= mem[rp];
        rp <= rp + 1'b1;
      end
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp <= wp + 1'b1;
      end
      cnt <= cnt + (LW+1)'(wr_en) - (LW+1)'(fifo_read);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor
  typedef struct { logic [31:0] word; logic last; int cyc; } xfer_t;
  xfer_t       cap[$];
  int          pops_n = 0, data_n = 0, pop_viol = 0, stall_viol = 0;
  logic        expect_hdr = 1'b1, stall_prev = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      pops_n <= 0; data_n <= 0; expect_hdr <= 1'b1; stall_prev <= 1'b0;
    end else begin
      if (fifo_read) begin
        if (fifo_empty || (pops_n - data_n) >= 3) pop_viol <= pop_viol + 1;
        pops_n <= pops_n + 1;
      end
      if (stall_prev && (!valid_o || data_o !== prev_data || last_o !== prev_last))
        stall_viol <= stall_viol + 1;
      if (valid_o && ready_i) begin
        cap.push_back('{data_o, last_o, cyc});
        if (!expect_hdr) data_n <= data_n + 1;
        expect_hdr <= last_o;
      end
      stall_prev <= valid_o && !ready_i;
      prev_data  <= data_o;
      prev_last  <= last_o;
    end
  end

  // Reference model: samples written, and the expected stream
  logic [WIDTH-1:0] ref_q[$];
  logic [31:0]      exp_w[$];
  logic             exp_l[$];
  int               model_seq = 0;
  int               passed = 0, total = 0;
  int               rmode = 0;

  task automatic build_bursts(input int k);
    int n;
    while (k > 0) begin
      n = (k > BURST) ? BURST : k;
      exp_w.push_back({8'hA5, 8'(model_seq), 16'(n)});
      exp_l.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
        exp_w.push_back(32'(ref_q.pop_front()));
        exp_l.push_back(i == n - 1);
      end
      model_seq = (model_seq + 1) % 256;
      k -= n;
    end
  endtask

  task automatic drive_ready();
    case (rmode)
      0:       ready_i = 1'b1;
      1:       ready_i = ~ready_i;
      default: ready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic tick();
    drive_ready();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] v);
    wr_en = 1'b1; wr_data = v;
    ref_q.push_back(v);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (cap.size() >= n) begin ok = 1'b1; break; end
      tick();
    end
    if (cap.size() >= n) ok = 1'b1;
  endtask

  task automatic fresh();
    cap.delete(); exp_w.delete(); exp_l.delete();
  endtask

  task automatic test_reset();
    total++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_o); else passed++;
    total++; if (fifo_read !== 1'b0) $display("FAIL reset_read got %b want 0", fifo_read); else passed++;
    total++; if (last_o !== 1'b0) $display("FAIL reset_last got %b want 0", last_o); else passed++;
    total++; if (data_o !== 32'd0) $display("FAIL reset_data got %h want 0", data_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else passed++;
    total++; if (seq_o !== 8'd0) $display("FAIL reset_seq got %0d want 0", seq_o); else passed++;
  endtask

  task automatic test_single_burst();
    bit ok;
    int pv, sv;
    fresh(); rmode = 0; enable_i = 1'b1; pv = pop_viol; sv = stall_viol;
    for (int i = 0; i < 8; i++) push_word(WIDTH'(200 + i));
    build_bursts(8);
    wait_words(9, 200, ok);
    repeat (5) tick();
    total++; if (!ok || cap.size() != 9) $display("FAIL single_count got %0d want 9", cap.size()); else passed++;
    for (int i = 0; i < exp_w.size() && i < cap.size(); i++) begin
      total++;
      if (cap[i].word !== exp_w[i] || cap[i].last !== exp_l[i])
        $display("FAIL single_word[%0d] got %h/%b want %h/%b", i, cap[i].word, cap[i].last, exp_w[i], exp_l[i]);
      else passed++;
    end
    for (int i = 2; i < cap.size(); i++) begin
      total++;
      if (cap[i].cyc !== cap[i-1].cyc + 1) $display("FAIL single_rate[%0d] got gap %0d want 1", i, cap[i].cyc - cap[i-1].cyc);
      else passed++;
    end
    total++; if (seq_o !== 8'(model_seq)) $display("FAIL single_seq got %0d want %0d", seq_o, model_seq); else passed++;
    total++; if (pop_viol != pv || stall_viol != sv) $display("FAIL single_rules got %0d/%0d want %0d/%0d", pop_viol, stall_viol, pv, sv); else passed++;
  endtask

  task automatic test_timeout();
    bit ok;
    int c0;
    fresh(); rmode = 0; enable_i = 1'b1;
    push_word(WIDTH'($urandom));
    c0 = cyc;
    push_word(WIDTH'($urandom));
    push_word(WIDTH'($urandom));
    build_bursts(3);
    repeat (40) tick();
    total++; if (cap.size() != 0) $display("FAIL timeout_early got %0d words want 0", cap.size()); else passed++;
    wait_words(4, 200, ok);
    repeat (5) tick();
    total++; if (!ok || cap.size() != 4) $display("FAIL timeout_count got %0d want 4", cap.size()); else passed++;
    if (cap.size() > 0) begin
      total++; if (cap[0].cyc - c0 != TIMEOUT) $display("FAIL timeout_delay got %0d want %0d", cap[0].cyc - c0, TIMEOUT); else passed++;
    end
    for (int i = 0; i < exp_w.size() && i < cap.size(); i++) begin
      total++;
      if (cap[i].word !== exp_w[i] || cap[i].last !== exp_l[i])
        $display("FAIL timeout_word[%0d] got %h/%b want %h/%b", i, cap[i].word, cap[i].last, exp_w[i], exp_l[i]);
      else passed++;
    end
  endtask

  task automatic test_stall();
    bit ok;
    int pv, sv;
    for (int m = 1; m <= 2; m++) begin
      fresh(); rmode = m; enable_i = 1'b1; pv = pop_viol; sv = stall_viol;
      for (int i = 0; i < 8; i++) push_word(WIDTH'($urandom));
      build_bursts(8);
      wait_words(9, 400, ok);
      rmode = 0; repeat (5) tick();
      total++; if (!ok || cap.size() != 9) $display("FAIL stall%0d_count got %0d want 9", m, cap.size()); else passed++;
      for (int i = 0; i < exp_w.size() && i < cap.size(); i++) begin
        total++;
        if (cap[i].word !== exp_w[i] || cap[i].last !== exp_l[i])
          $display("FAIL stall%0d_word[%0d] got %h/%b want %h/%b", m, i, cap[i].word, cap[i].last, exp_w[i], exp_l[i]);
        else passed++;
      end
      total++; if (stall_viol != sv) $display("FAIL stall%0d_hold got %0d violations want 0", m, stall_viol - sv); else passed++;
      total++; if (pop_viol != pv) $display("FAIL stall%0d_pop got %0d violations want 0", m, pop_viol - pv); else passed++;
    end
  endtask

  task automatic test_full_fifo();
    bit ok;
    fresh(); rmode = 0; enable_i = 1'b0;
    for (int i = 0; i < LENGTH; i++) push_word(WIDTH'($urandom));
    repeat (5) tick();
    total++; if (cap.size() != 0) $display("FAIL full_idle got %0d words want 0", cap.size()); else passed++;
    build_bursts(LENGTH);
    enable_i = 1'b1;
    wait_words(exp_w.size(), 400, ok);
    repeat (5) tick();
    total++; if (!ok || cap.size() != exp_w.size()) $display("FAIL full_count got %0d want %0d", cap.size(), exp_w.size()); else passed++;
    for (int i = 0; i < exp_w.size() && i < cap.size(); i++) begin
      total++;
      if (cap[i].word !== exp_w[i] || cap[i].last !== exp_l[i])
        $display("FAIL full_word[%0d] got %h/%b want %h/%b", i, cap[i].word, cap[i].last, exp_w[i], exp_l[i]);
      else passed++;
    end
    total++; if (fifo_empty !== 1'b1) $display("FAIL full_drained got empty=%b want 1", fifo_empty); else passed++;
    total++; if (seq_o !== 8'(model_seq)) $display("FAIL full_seq got %0d want %0d", seq_o, model_seq); else passed++;
  endtask

  task automatic test_enable_pulse();
    bit ok;
    fresh(); rmode = 0; enable_i = 1'b0;
    for (int i = 0; i < 16; i++) push_word(WIDTH'($urandom));
    repeat (20) tick();
    total++; if (cap.size() != 0) $display("FAIL pulse_idle got %0d words want 0", cap.size()); else passed++;
    build_bursts(8);
    enable_i = 1'b1; tick(); enable_i = 1'b0;
    repeat (80) tick();
    total++; if (cap.size() != 9) $display("FAIL pulse_count got %0d want 9", cap.size()); else passed++;
    for (int i = 0; i < exp_w.size() && i < cap.size(); i++) begin
      total++;
      if (cap[i].word !== exp_w[i] || cap[i].last !== exp_l[i])
        $display("FAIL pulse_word[%0d] got %h/%b want %h/%b", i, cap[i].word, cap[i].last, exp_w[i], exp_l[i]);
      else passed++;
    end
    total++; if (busy_o !== 1'b0) $display("FAIL pulse_busy got %b want 0", busy_o); else passed++;
    fresh(); build_bursts(8);
    enable_i = 1'b1;
    wait_words(9, 200, ok);
    repeat (5) tick();
    total++; if (!ok || cap.size() != 9) $display("FAIL pulse_rest_count got %0d want 9", cap.size()); else passed++;
    for (int i = 0; i < exp_w.size() && i < cap.size(); i++) begin
      total++;
      if (cap[i].word !== exp_w[i] || cap[i].last !== exp_l[i])
        $display("FAIL pulse_rest_word[%0d] got %h/%b want %h/%b", i, cap[i].word, cap[i].last, exp_w[i], exp_l[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    fresh(); rmode = 0; enable_i = 1'b1;
    for (int i = 0; i < 8; i++) push_word(WIDTH'($urandom));
    wait_words(4, 200, ok);
    total++; if (!ok || busy_o !== 1'b1) $display("FAIL midrst_reach got busy=%b want 1", busy_o); else passed++;
    rst = 1'b1; ready_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (valid_o !== 1'b0) $display("FAIL midrst_valid got %b want 0", valid_o); else passed++;
    total++; if (data_o !== 32'd0) $display("FAIL midrst_data got %h want 0", data_o); else passed++;
    total++; if (busy_o !== 1'b0 || last_o !== 1'b0) $display("FAIL midrst_busy got %b/%b want 0/0", busy_o, last_o); else passed++;
    total++; if (seq_o !== 8'd0) $display("FAIL midrst_seq got %0d want 0", seq_o); else passed++;
    total++; if (fifo_read !== 1'b0) $display("FAIL midrst_read got %b want 0", fifo_read); else passed++;
    ref_q.delete(); model_seq = 0; fresh();
    for (int i = 0; i < 8; i++) push_word(WIDTH'($urandom));
    build_bursts(8);
    wait_words(9, 200, ok);
    repeat (5) tick();
    total++; if (!ok || cap.size() != 9) $display("FAIL midrst_count got %0d want 9", cap.size()); else passed++;
    for (int i = 0; i < exp_w.size() && i < cap.size(); i++) begin
      total++;
      if (cap[i].word !== exp_w[i] || cap[i].last !== exp_l[i])
        $display("FAIL midrst_word[%0d] got %h/%b want %h/%b", i, cap[i].word, cap[i].last, exp_w[i], exp_l[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    bit ok;
    int k, pv, sv;
    for (int it = 0; it < 4; it++) begin
      fresh(); rmode = 0; enable_i = 1'b0; pv = pop_viol; sv = stall_viol;
      k = $urandom_range(1, LENGTH);
      for (int i = 0; i < k; i++) push_word(WIDTH'($urandom));
      build_bursts(k);
      rmode = 2; enable_i = 1'b1;
      wait_words(exp_w.size(), 2000, ok);
      rmode = 0; repeat (5) tick();
      total++; if (!ok || cap.size() != exp_w.size()) $display("FAIL rand%0d_count got %0d want %0d", it, cap.size(), exp_w.size()); else passed++;
      for (int i = 0; i < exp_w.size() && i < cap.size(); i++) begin
        total++;
        if (cap[i].word !== exp_w[i] || cap[i].last !== exp_l[i])
          $display("FAIL rand%0d_word[%0d] got %h/%b want %h/%b", it, i, cap[i].word, cap[i].last, exp_w[i], exp_l[i]);
        else passed++;
      end
      total++; if (pop_viol != pv || stall_viol != sv) $display("FAIL rand%0d_rules got %0d/%0d new violations want 0/0", it, pop_viol - pv, stall_viol - sv); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_single_burst();
    test_timeout();
    test_stall();
    test_full_fifo();
    test_enable_pulse();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
